// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU path (A) over
// load path (B) with a starvation override, plus a pending-load scoreboard.
module regfile_wb_arbiter #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_req,
   input  logic [ADDR_W-1:0]    a_addr,
   input  logic [DATA_W-1:0]    a_data,
   output logic                 a_ack,
   input  logic                 b_req,
   input  logic [ADDR_W-1:0]    b_addr,
   input  logic [DATA_W-1:0]    b_data,
   output logic                 b_ack,
   input  logic                 claim_valid,
   input  logic [ADDR_W-1:0]    claim_addr,
   input  logic [ADDR_W-1:0]    chk_add_1,
   input  logic [ADDR_W-1:0]    chk_add_2,
   output logic                 hazard_1,
   output logic                 hazard_2,
   output logic [2**ADDR_W-1:0] busy,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_reg_add,
   output logic [DATA_W-1:0]    wr_data
);

   localparam int         NREG  = 2**ADDR_W;
   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   typedef enum logic {NORMAL, FORCE_B} state_t;

   state_t          state, state_nxt;
   logic [2:0]      starve_cnt, starve_cnt_nxt, starve_inc;
   logic [NREG-1:0] busy_nxt;

   // Stage 0: grant decision and starvation tracking
   always_comb begin
      a_ack          = 1'b0;
      b_ack          = 1'b0;
      state_nxt      = NORMAL;
      starve_cnt_nxt = 3'd0;
      starve_inc     = starve_cnt + 3'd1;
      if (!rst) begin
         if (state == FORCE_B && b_req) b_ack = 1'b1;
         else if (a_req)                a_ack = 1'b1;
         else if (b_req)                b_ack = 1'b1;
      end
      if (b_req && !b_ack) begin
         if (state == NORMAL && starve_inc == LIMIT) state_nxt = FORCE_B;
         else                                        starve_cnt_nxt = starve_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= NORMAL;
         starve_cnt <= 3'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // A new claim beats a same-cycle B completion on the same register
   always_comb begin
      busy_nxt = busy;
      if (b_ack)       busy_nxt[b_addr]     = 1'b0;
      if (claim_valid) busy_nxt[claim_addr] = 1'b1;
   end

   assign hazard_1 = busy[chk_add_1];
   assign hazard_2 = busy[chk_add_2];

   // Stage 1: registered write port and scoreboard
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= '0;
         wr_en      <= 1'b0;
         wr_reg_add <= '0;
         wr_data    <= '0;
      end else begin
         busy  <= busy_nxt;
         wr_en <= a_ack | b_ack;
         if (a_ack) begin
            wr_reg_add <= a_addr;
            wr_data    <= a_data;
         end else if (b_ack) begin
            wr_reg_add <= b_addr;
            wr_data    <= b_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model of the grant, write and scoreboard rules.
module tb_regfile_wb_arbiter;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int LIMIT  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              a_req = 1'b0, b_req = 1'b0, claim_valid = 1'b0;
   logic [ADDR_W-1:0] a_addr = '0, b_addr = '0, claim_addr = '0, chk_add_1 = '0, chk_add_2 = '0;
   logic [DATA_W-1:0] a_data = '0, b_data = '0;
   logic              a_ack, b_ack, hazard_1, hazard_2, wr_en;
   logic [15:0]       busy;
   logic [ADDR_W-1:0] wr_reg_add;
   logic [DATA_W-1:0] wr_data;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_force;
   int          m_wait;
   bit          m_wr_en;
   logic [3:0]  m_addr;
   logic [15:0] m_data;
   bit          m_busy [16];
   bit          last_ga, last_gb;

   regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
      .claim_valid(claim_valid), .claim_addr(claim_addr),
      .chk_add_1(chk_add_1), .chk_add_2(chk_add_2),
      .hazard_1(hazard_1), .hazard_2(hazard_2), .busy(busy),
      .wr_en(wr_en), .wr_reg_add(wr_reg_add), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] model_busy_vec();
      logic [15:0] v;
      for (int i = 0; i < 16; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // who should win this cycle, given the present inputs and model history
   task automatic model_grant(output bit ga, output bit gb);
      ga = 0; gb = 0;
      if (!rst) begin
         if (m_force && b_req) gb = 1;
         else if (a_req)       ga = 1;
         else if (b_req)       gb = 1;
      end
   endtask

   task automatic model_reset();
      m_force = 0; m_wait = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
      for (int i = 0; i < 16; i++) m_busy[i] = 0;
   endtask

   task automatic model_update();
      bit ga, gb, force_next;
      model_grant(ga, gb);
      last_ga = ga; last_gb = gb;
      if (rst) begin
         model_reset();
         return;
      end
      m_wr_en = ga | gb;
      if (ga) begin m_addr = a_addr; m_data = a_data; end
      else if (gb) begin m_addr = b_addr; m_data = b_data; end
      if (gb) m_busy[b_addr] = 0;
      if (claim_valid) m_busy[claim_addr] = 1;
      // B has been refused m_wait cycles in a row; after LIMIT refusals it is owed the next slot
      force_next = 0;
      if (b_req && !gb) begin
         m_wait++;
         if (m_wait >= LIMIT) begin force_next = 1; m_wait = 0; end
      end else begin
         m_wait = 0;
      end
      m_force = force_next;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      a_req = 0; b_req = 0; claim_valid = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
      total++; if (busy !== 16'h0) begin bad++; $display("FAIL reset_busy got=%h want=0000", busy); end
      total++; if (wr_data !== 16'h0 || wr_reg_add !== 4'h0) begin bad++; $display("FAIL reset_wr got=%h/%h want=0/0", wr_reg_add, wr_data); end
      rst = 0;
      claim_valid = 1; claim_addr = 4'd0;
      tick();
      claim_addr = 4'd7; a_req = 1; a_addr = 4'd1; a_data = 16'h0005;
      tick();
      total++; if (busy !== 16'h0081 || wr_en !== 1'b1) begin bad++; $display("FAIL pre_reset_state got=%h/%b want=0081/1", busy, wr_en); end
      #3 rst = 1;
      #1;
      total++; if (busy !== 16'h0 || wr_en !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b want=0000/0", busy, wr_en); end
      total++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin bad++; $display("FAIL reset_acks got=%b%b want=00", a_ack, b_ack); end
      idle_inputs();
      tick();
      rst = 0;
      tick();
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b want=0", wr_en); end
   endtask

   task automatic test_single_a();
      a_req = 1; a_addr = 4'd5; a_data = 16'hBEEF;
      #1;
      total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL single_a_ack got=%b%b want=10", a_ack, b_ack); end
      tick();
      a_req = 0;
      total++; if (wr_en !== 1'b1 || wr_reg_add !== 4'd5 || wr_data !== 16'hBEEF) begin bad++; $display("FAIL single_a_write got=%b/%h/%h want=1/5/beef", wr_en, wr_reg_add, wr_data); end
      tick();
      total++; if (wr_en !== 1'b0 || wr_reg_add !== 4'd5 || wr_data !== 16'hBEEF) begin bad++; $display("FAIL single_a_hold got=%b/%h/%h want=0/5/beef", wr_en, wr_reg_add, wr_data); end
   endtask

   task automatic test_starvation();
      logic [15:0] d;
      b_req = 1; b_addr = 4'd9; b_data = 16'h1234;
      for (int i = 0; i < 5; i++) begin
         d = 16'($urandom);
         a_req = 1; a_addr = 4'(i); a_data = d;
         if (i == 4) b_req = 0;
         #1;
         total++;
         if (a_ack !== (i != 3) || b_ack !== (i == 3)) begin bad++; $display("FAIL starve_ack cyc=%0d got=%b%b want=%b%b", i, a_ack, b_ack, i != 3, i == 3); end
         tick();
         total++;
         if (i == 3) begin
            if (wr_en !== 1'b1 || wr_reg_add !== 4'd9 || wr_data !== 16'h1234) begin bad++; $display("FAIL starve_b_write got=%b/%h/%h want=1/9/1234", wr_en, wr_reg_add, wr_data); end
         end else begin
            if (wr_en !== 1'b1 || wr_reg_add !== 4'(i) || wr_data !== d) begin bad++; $display("FAIL starve_a_write cyc=%0d got=%h/%h want=%h/%h", i, wr_reg_add, wr_data, i, d); end
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_force_withdrawn();
      b_addr = 4'd2; b_data = 16'h5555; a_addr = 4'd4; a_data = 16'hAAAA;
      for (int i = 0; i < 8; i++) begin
         a_req = 1;
         b_req = (i != 3);
         #1;
         total++;
         if (a_ack !== (i != 7) || b_ack !== (i == 7)) begin bad++; $display("FAIL force_withdrawn_ack cyc=%0d got=%b%b want=%b%b", i, a_ack, b_ack, i != 7, i == 7); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_scoreboard();
      claim_valid = 1; claim_addr = 4'd7; chk_add_1 = 4'd7; chk_add_2 = 4'd7;
      #1;
      total++; if (hazard_1 !== 1'b0) begin bad++; $display("FAIL sb_no_bypass got=%b want=0", hazard_1); end
      tick();
      claim_valid = 0;
      total++; if (busy[7] !== 1'b1 || hazard_1 !== 1'b1 || hazard_2 !== 1'b1) begin bad++; $display("FAIL sb_set got=%b%b%b want=111", busy[7], hazard_1, hazard_2); end
      b_req = 1; b_addr = 4'd7; b_data = 16'h0777;
      #1;
      total++; if (b_ack !== 1'b1 || hazard_1 !== 1'b1) begin bad++; $display("FAIL sb_clear_not_early got=%b/%b want=1/1", b_ack, hazard_1); end
      tick();
      b_req = 0;
      total++; if (busy[7] !== 1'b0 || hazard_1 !== 1'b0) begin bad++; $display("FAIL sb_clear got=%b/%b want=0/0", busy[7], hazard_1); end
      claim_valid = 1; claim_addr = 4'd7; b_req = 1; b_addr = 4'd7;
      tick();
      claim_valid = 0; b_req = 0;
      total++; if (busy[7] !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b want=1", busy[7]); end
      b_req = 1;
      tick();
      b_req = 0;
      total++; if (busy !== 16'h0) begin bad++; $display("FAIL sb_empty got=%h want=0000", busy); end
   endtask

   task automatic test_collision();
      claim_valid = 1; claim_addr = 4'd3;
      tick();
      claim_valid = 0;
      a_req = 1; a_addr = 4'd3; a_data = 16'h0001;
      b_req = 1; b_addr = 4'd3; b_data = 16'h0002;
      #1;
      total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) begin bad++; $display("FAIL collide_first got=%b%b want=10", a_ack, b_ack); end
      tick();
      a_req = 0;
      total++; if (wr_en !== 1'b1 || wr_reg_add !== 4'd3 || wr_data !== 16'h0001 || busy[3] !== 1'b1) begin bad++; $display("FAIL collide_a_write got=%h/%h busy3=%b want=3/0001/1", wr_reg_add, wr_data, busy[3]); end
      #1;
      total++; if (b_ack !== 1'b1) begin bad++; $display("FAIL collide_second got=%b want=1", b_ack); end
      tick();
      b_req = 0;
      total++; if (wr_en !== 1'b1 || wr_reg_add !== 4'd3 || wr_data !== 16'h0002 || busy[3] !== 1'b0) begin bad++; $display("FAIL collide_b_write got=%h/%h busy3=%b want=3/0002/0", wr_reg_add, wr_data, busy[3]); end
      tick();
   endtask

   task automatic test_random();
      bit ga, gb;
      for (int n = 0; n < 400; n++) begin
         if (!a_req && $urandom_range(0, 2) == 0) begin
            a_req = 1; a_addr = 4'($urandom_range(0, 15)); a_data = 16'($urandom);
         end
         if (!b_req && $urandom_range(0, 1) == 0) begin
            b_req = 1; b_addr = 4'($urandom_range(0, 15)); b_data = 16'($urandom);
         end
         claim_valid = ($urandom_range(0, 3) == 0);
         claim_addr  = 4'($urandom_range(0, 15));
         chk_add_1   = 4'($urandom_range(0, 15));
         chk_add_2   = 4'($urandom_range(0, 15));
         #1;
         model_grant(ga, gb);
         total++;
         if (a_ack !== ga || b_ack !== gb) begin bad++; $display("FAIL rand_ack n=%0d got=%b%b want=%b%b", n, a_ack, b_ack, ga, gb); end
         total++;
         if (hazard_1 !== m_busy[chk_add_1] || hazard_2 !== m_busy[chk_add_2]) begin bad++; $display("FAIL rand_hazard n=%0d got=%b%b want=%b%b", n, hazard_1, hazard_2, m_busy[chk_add_1], m_busy[chk_add_2]); end
         tick();
         total++;
         if (wr_en !== m_wr_en || wr_reg_add !== m_addr || wr_data !== m_data || busy !== model_busy_vec()) begin
            bad++;
            $display("FAIL rand_write n=%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", n, wr_en, wr_reg_add, wr_data, busy, m_wr_en, m_addr, m_data, model_busy_vec());
         end
         if (last_ga) a_req = 0;
         if (last_gb) b_req = 0;
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_a();
      test_starvation();
      test_force_withdrawn();
      test_scoreboard();
      test_collision();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back controller in front of the 16x16 register file's single write port.
- Shares that port between two producers, with fixed priority plus an anti-starvation override:
  - A: ALU result path, normally higher priority.
  - B: load/memory return path.
- Keeps a per-register pending-load scoreboard so decode can stall on read-after-load hazards.
- Drives the register file's wr_en/wr_reg_add/wr_data from registered outputs.

Parameters:
DATA_W, 16, write data width
ADDR_W, 4, register address width (2**ADDR_W registers)
STARVE_LIMIT, 3, consecutive denied B cycles before B is forced to win (range 1..7)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
a_req  input  1  A has a write pending; held until a_ack
a_addr  input  ADDR_W  A destination register
a_data  input  DATA_W  A write data
a_ack  output  1  combinational grant to A this cycle
b_req  input  1  B has a write pending; held until b_ack
b_addr  input  ADDR_W  B destination register
b_data  input  DATA_W  B write data
b_ack  output  1  combinational grant to B this cycle
claim_valid  input  1  load issued this cycle; reserve claim_addr
claim_addr  input  ADDR_W  destination of issued load
chk_add_1  input  ADDR_W  decode read address 1
chk_add_2  input  ADDR_W  decode read address 2
hazard_1  output  1  busy[chk_add_1], combinational
hazard_2  output  1  busy[chk_add_2], combinational
busy  output  2**ADDR_W  scoreboard, one bit per register
wr_en  output  1  registered write enable to register file
wr_reg_add  output  ADDR_W  registered write address
wr_data  output  DATA_W  registered write data

Behaviour:
- Reset (async, rst=1): wr_en=0, wr_reg_add=0, wr_data=0, busy=0, starve counter=0, FSM=NORMAL. a_ack=b_ack=0 while rst=1.
- FSM NORMAL grant rule:
  - a_req=1: A wins.
  - otherwise b_req=1: B wins.
  - neither: no grant.
- FSM FORCE_B grant rule:
  - b_req=1: B wins even if a_req=1.
  - b_req=0: fall back to the NORMAL rule.
- FSM FORCE_B always returns to NORMAL next cycle.
- Starve counter, 3 bits, updated each cycle:
  - b_req=1 and b_ack=0: increment.
  - otherwise: clear.
  - In NORMAL, when the incremented value equals STARVE_LIMIT: go to FORCE_B next cycle and clear the counter.
- Max B wait is STARVE_LIMIT cycles; B is granted on cycle STARVE_LIMIT+1.
- Ack/write timing:
  - Ack is asserted in the same cycle as the grant.
  - On the next rising edge: wr_en=1, wr_reg_add and wr_data = winner's addr/data.
  - Write-port latency is 1 cycle after grant.
  - No grant: wr_en=0; wr_reg_add/wr_data hold their previous values.
- At most one ack per cycle; back-to-back grants give a write every cycle (full throughput).
- A requester seeing ack may present a new request in the next cycle.
- Same destination requested by A and B in one cycle: winner writes first, loser writes in a later cycle. Last write wins in the register file; no merging.
- Scoreboard, per bit, at each edge:
  - Set when claim_valid=1 and claim_addr=i.
  - Clear when b_ack=1 and b_addr=i.
  - Simultaneous set and clear on the same i: set wins (a new load is outstanding).
  - A writes do not touch busy.
- hazard_n reflects the registered busy bit only.
  - No bypass from the same-cycle claim.
  - Not cleared early by a same-cycle b_ack.
- claim_valid on an already-busy register: bit stays 1 and the scoreboard does not count. Issue logic must not issue two outstanding loads to the same register.
- Reset mid-operation (e.g. B pending, FSM=FORCE_B, busy bits set):
  - Everything returns to reset values immediately.
  - Any grant pending at the reset edge is lost; requesters re-request after reset.

Test Plan:
- Reset: assert rst mid-cycle with busy=16'h0081 and wr_en=1 -> busy=0, wr_en=0, acks=0 immediately; after release with no requests, wr_en stays 0.
- Single A: a_req=1, a_addr=5, a_data=16'hBEEF for one cycle -> a_ack=1 that cycle; next edge wr_en=1, wr_reg_add=5, wr_data=16'hBEEF; following cycle wr_en=0.
- Contention and starvation (STARVE_LIMIT=3):
  - Stimulus: a_req held high with new data each cycle; b_req=1, b_addr=9, b_data=16'h1234 from cycle 0.
  - a_ack in cycles 0-2; b_ack in cycle 3 only; a_ack again in cycle 4.
  - wr_reg_add=9, wr_data=16'h1234 at edge after cycle 3.
- FORCE_B with B withdrawn: drive to FORCE_B, then drop b_req in that cycle while a_req=1 -> a_ack=1, b_ack=0, FSM back to NORMAL, counter=0.
- Scoreboard:
  - claim_valid=1, claim_addr=7 -> next cycle busy[7]=1, hazard_1=1 when chk_add_1=7.
  - Later b_ack with b_addr=7 -> busy[7]=0 next cycle.
  - claim and b_ack on addr 7 in the same cycle -> busy[7] stays 1.
- Same-address collision: a_req and b_req both to reg 3 (A=16'h0001, B=16'h0002) -> writes 16'h0001 then 16'h0002 on consecutive edges; busy[3] cleared after the B write.
